rptr_empty_fwft: RTL
====================

# rptr_empty_fwft

Read-side pointer, empty-flag and first-word-fall-through output stage of the dual-clock FIFO. It consumes the write pointer after it has been synchronised into the read domain, as a Gray code `rq2_wptr`, and publishes the Gray read pointer `rptr` back toward the write domain. It drives the read port of the FIFO memory, which has one cycle of synchronous read latency. It presents words to the consumer through a 2-entry valid/ready output buffer.

## Interface
- `DSIZE`, 8, data width.
- `ADDRSIZE`, 4, memory address width; depth is 2^ADDRSIZE.
- `AE_LEVEL`, 2, almost-empty threshold, in words not yet fetched.

- `rclk`  in  1  read-domain clock; the only clock.
- `rrst`  in  1  reset, asynchronous, active-high.
- `rq2_wptr`  in  ADDRSIZE+1  synchronised Gray write pointer.
- `rptr`  out  ADDRSIZE+1  registered Gray read pointer.
- `raddr`  out  ADDRSIZE  memory read address.
- `rmem_en`  out  1  memory read strobe.
- `rmem_data`  in  DSIZE  memory data; valid on the edge after an `rmem_en` cycle.
- `rdata`  out  DSIZE  head word of the output buffer.
- `rvalid`  out  1  `rdata` is valid.
- `rready`  in  1  consumer accepts `rdata`.
- `rempty`  out  1  no unfetched words remain in memory.
- `ralmost_empty`  out  1  `rlevel` <= `AE_LEVEL`.
- `rlevel`  out  ADDRSIZE+1  unfetched words in memory.

## Operation
- Internal registers: binary pointer `rbin`, Gray pointer `rptr`, `rempty`, `inflight` flag, 2-entry buffer with `held` count (0..2), `rlevel`, `ralmost_empty`.
- `pop` = `rvalid` & `rready`.
- `fetch` = !`rempty` & (`held` + `inflight` − `pop` < 2).
- `rmem_en` = `fetch`, combinational.
- `raddr` = `rbin[ADDRSIZE-1:0]`, combinational from the register.
- `rbinnext` = `rbin` + `fetch`.
- `rgraynext` = (`rbinnext`>>1) ^ `rbinnext`.
- Every edge: `rbin`<=`rbinnext`; `rptr`<=`rgraynext`; `rempty`<=(`rgraynext`==`rq2_wptr`); `inflight`<=`fetch`.
- Level: `wbin` = Gray-to-binary of `rq2_wptr`. `rlevel`<=(`wbin`−`rbinnext`) mod 2^(ADDRSIZE+1). `ralmost_empty`<=(that value <= `AE_LEVEL`).
- Pointer arithmetic is ADDRSIZE+1 bits and wraps naturally. The MSB distinguishes laps, so `rlevel` is correct across wrap-around.
- Output buffer:
  - Strict FIFO order; `rdata` = head entry; `rvalid` = (`held` != 0).
  - When `inflight` is 1, `rmem_data` is written at the tail on that edge.
  - A simultaneous `pop` removes the head on the same edge.
  - Simultaneous write and pop with `held`==1: the new word becomes head and `held` stays 1.
- `rdata` is stable while `rvalid` & !`rready`.
- The `fetch` rule guarantees `held` + `inflight` never exceeds 2, so no overflow is possible and no word is lost.
- No read ever occurs while `rempty`=1.
- `rempty` is conservative: a `rq2_wptr` advance is seen one edge late. A `rempty` fall never loses data.

## Timing
- Reset values: `rptr`=0, `rbin`=0, `rempty`=1, `ralmost_empty`=1, `rlevel`=0, `rvalid`=0, `held`=0, `inflight`=0, `rdata`=0. `rmem_en`=0 follows from `rempty`=1.
- Reset asserted mid-operation: all state clears immediately, asynchronously. Buffered and in-flight words are discarded. The rmem_data arriving after reset is ignored.
- Latency from a `rq2_wptr` change at edge k on an empty FIFO:
  - `rempty` falls at edge k+1.
  - `rmem_en` is high in the cycle after k+1.
  - `rvalid` rises at edge k+3.
- Throughput with `rready` held high: one word per cycle, sustained.
- With `rready` low: at most 2 words are fetched, then `rmem_en` stays 0 until a pop.
- After a pop frees a slot, `rmem_en` reasserts in the same cycle as the pop (combinational `fetch`).
- `rempty` rises on the edge where the last unfetched word is read.

## Test plan
- Reset: assert `rrst` mid-burst with `rq2_wptr`=0 held → all outputs at their reset values asynchronously; after release `rempty`=1, `rptr`=0, `rvalid`=0.
- Single word: `rq2_wptr` 0→1 at edge k, memory word 0xA5 → `rempty` low at k+1, `rmem_en` one cycle at `raddr`=0, `rvalid` at k+3 with `rdata`=0xA5, `rptr`=1, `rempty`=1 afterwards.
- Burst with `rready`=1: 8 words 0x10..0x17 available → `rvalid` continuous for 8 cycles, in order; `rlevel` counts 8→0; `ralmost_empty` rises when `rlevel` reaches 2.
- Backpressure: 6 words available, `rready`=0 → exactly 2 `rmem_en` pulses, `held`=2, `rdata`=word0 stable. Then `rready`=1 → words 0..5 in order, no gaps after the first.
- Wrap-around: stream 2×16+3 words (ADDRSIZE=4) with random `rready` → `rptr` passes 5'b10000 and back to low values; data matches, `rlevel` never exceeds 16.
- Simultaneous events: `rq2_wptr` advances on the same edge as the pop of the last buffered word → no duplicated or dropped word; `rempty` falls on the next edge.

Source files
------------

// File: rtl/rptr_empty_fwft_if.sv
// Read-side bus of the dual-clock FIFO: synchronised write pointer in, Gray read
// pointer out, memory read port, and the valid/ready consumer port.
interface rptr_empty_fwft_if #(
    parameter int DSIZE    = 8,
    parameter int ADDRSIZE = 4
);
    logic [ADDRSIZE:0]   rq2_wptr;
    logic [ADDRSIZE:0]   rptr;
    logic [ADDRSIZE-1:0] raddr;
    logic                rmem_en;
    logic [DSIZE-1:0]    rmem_data;
    logic [DSIZE-1:0]    rdata;
    logic                rvalid;
    logic                rready;
    logic                rempty;
    logic                ralmost_empty;
    logic [ADDRSIZE:0]   rlevel;

    modport slave (
        input  rq2_wptr, rmem_data, rready,
        output rptr, raddr, rmem_en, rdata, rvalid, rempty, ralmost_empty, rlevel
    );

    modport master (
        output rq2_wptr, rmem_data, rready,
        input  rptr, raddr, rmem_en, rdata, rvalid, rempty, ralmost_empty, rlevel
    );
endinterface

// File: rtl/rptr_empty_fwft.sv
// Read pointer / empty flag / level tracking with a 2-entry first-word-fall-through
// buffer in front of a memory that has one cycle of read latency.
module rptr_empty_fwft #(
    parameter int DSIZE    = 8,
    parameter int ADDRSIZE = 4,
    parameter int AE_LEVEL = 2
) (
    input  logic               rclk,
    input  logic               rrst,
    rptr_empty_fwft_if.slave   bus
);
    localparam logic [ADDRSIZE:0] AE_THRESH = (ADDRSIZE + 1)'(AE_LEVEL);

    logic [ADDRSIZE:0] rbin_q, rbin_d;
    logic [ADDRSIZE:0] rptr_q, rptr_d;
    logic [ADDRSIZE:0] rlevel_q, rlevel_d;
    logic [ADDRSIZE:0] wbin;
    logic              rempty_q, rempty_d;
    logic              ae_q, ae_d;
    logic              inflight_q;
    logic [1:0]        held_q, held_d;
    logic [DSIZE-1:0]  buf_q [2];
    logic [DSIZE-1:0]  buf_d [2];
    logic              pop;
    logic              fetch;
    logic [2:0]        occ_after;

    // Buffered plus in-flight words never exceed the two buffer slots.
    assign pop       = (held_q != 2'd0) && bus.rready;
    assign occ_after = {1'b0, held_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign fetch     = !rempty_q && (occ_after < 3'd2);

    assign rbin_d   = rbin_q + {{ADDRSIZE{1'b0}}, fetch};
    assign rptr_d   = (rbin_d >> 1) ^ rbin_d;
    assign rempty_d = (rptr_d == bus.rq2_wptr);

    for (genvar gi = 0; gi <= ADDRSIZE; gi++) begin : g_gray2bin
        assign wbin[gi] = ^bus.rq2_wptr[ADDRSIZE:gi];
    end

    assign rlevel_d = wbin - rbin_d;
    assign ae_d     = (rlevel_d <= AE_THRESH);

    // Pop shifts the head out first; an arriving word then lands at the new tail.
    always_comb begin
        buf_d[0] = buf_q[0];
        buf_d[1] = buf_q[1];
        held_d   = held_q;
        if (pop) begin
            buf_d[0] = buf_q[1];
            held_d   = held_q - 2'd1;
        end
        if (inflight_q) begin
            if (held_d == 2'd0) begin
                buf_d[0] = bus.rmem_data;
            end else begin
                buf_d[1] = bus.rmem_data;
            end
            held_d = held_d + 2'd1;
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin_q     <= '0;
            rptr_q     <= '0;
            rempty_q   <= 1'b1;
            rlevel_q   <= '0;
            ae_q       <= 1'b1;
            inflight_q <= 1'b0;
            held_q     <= 2'd0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            rbin_q     <= rbin_d;
            rptr_q     <= rptr_d;
            rempty_q   <= rempty_d;
            rlevel_q   <= rlevel_d;
            ae_q       <= ae_d;
            inflight_q <= fetch;
            held_q     <= held_d;
            buf_q[0]   <= buf_d[0];
            buf_q[1]   <= buf_d[1];
        end
    end

    assign bus.rptr          = rptr_q;
    assign bus.raddr         = rbin_q[ADDRSIZE-1:0];
    assign bus.rmem_en       = fetch;
    assign bus.rdata         = buf_q[0];
    assign bus.rvalid        = (held_q != 2'd0);
    assign bus.rempty        = rempty_q;
    assign bus.ralmost_empty = ae_q;
    assign bus.rlevel        = rlevel_q;
endmodule
